// File: rtl/wb_issue_scheduler.sv
// rtl/wb_issue_scheduler.sv - issue scheduler that reserves the shared WB port for the ALU and multiplier paths
// It stalls decode on RAW/WAW hazards and WB-slot conflicts, and drives the WB mux select and write address.
module wb_issue_scheduler #(
    parameter int ALU_LAT = 2,
    parameter int MUL_LAT = 7,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             dec_valid_i,
    input  logic             dec_is_mul_i,
    input  logic [4:0]       dec_rs1_i,
    input  logic             dec_rs1_used_i,
    input  logic [4:0]       dec_rs2_i,
    input  logic             dec_rs2_used_i,
    input  logic [4:0]       dec_rd_i,
    input  logic             dec_rd_we_i,
    output logic             stall_o,
    output logic             issue_o,
    output logic             wb_valid_o,
    output logic             wb_sel_mul_o,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      pending_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [MUL_LAT-1:0]      v_q, v_d;
    logic [MUL_LAT-1:0]      mul_q, mul_d;
    logic [MUL_LAT-1:0][4:0] rd_q, rd_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

    logic reserve, raw, waw, port, hazard;

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            if (v_q[i]) pending_o[rd_q[i]] = 1'b1;
        end
        pending_o[0] = 1'b0;
    end

    always_comb begin
        reserve = dec_rd_we_i && (dec_rd_i != 5'd0);
        raw     = (dec_rs1_used_i && (dec_rs1_i != 5'd0) && pending_o[dec_rs1_i]) ||
                  (dec_rs2_used_i && (dec_rs2_i != 5'd0) && pending_o[dec_rs2_i]);
        waw     = reserve && pending_o[dec_rd_i];
        // The ALU slot is refilled by the shift from ALU_LAT at this same edge.
        port    = reserve && !dec_is_mul_i && v_q[ALU_LAT];
        hazard  = raw || waw || port;
        stall_o = rsn_i && dec_valid_i && hazard;
        issue_o = rsn_i && dec_valid_i && !hazard;
    end

    always_comb begin
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            v_d[i]   = v_q[i+1];
            mul_d[i] = mul_q[i+1];
            rd_d[i]  = rd_q[i+1];
        end
        v_d[MUL_LAT-1]   = 1'b0;
        mul_d[MUL_LAT-1] = 1'b0;
        rd_d[MUL_LAT-1]  = 5'd0;
        if (issue_o && reserve) begin
            if (dec_is_mul_i) begin
                v_d[MUL_LAT-1]   = 1'b1;
                mul_d[MUL_LAT-1] = 1'b1;
                rd_d[MUL_LAT-1]  = dec_rd_i;
            end else begin
                v_d[ALU_LAT-1]   = 1'b1;
                mul_d[ALU_LAT-1] = 1'b0;
                rd_d[ALU_LAT-1]  = dec_rd_i;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            v_q         <= '0;
            mul_q       <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            mul_q       <= mul_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wb_valid_o   = v_q[0];
    assign wb_sel_mul_o = v_q[0] & mul_q[0];
    assign wb_rd_o      = v_q[0] ? rd_q[0] : 5'd0;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_wb_issue_scheduler.sv
// tb/tb_wb_issue_scheduler.sv - directed self-checking bench for wb_issue_scheduler
module tb_wb_issue_scheduler;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        dec_valid_i, dec_is_mul_i, dec_rs1_used_i, dec_rs2_used_i, dec_rd_we_i;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic        stall_o, issue_o, wb_valid_o, wb_sel_mul_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] pending_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    wb_issue_scheduler #(.ALU_LAT(2), .MUL_LAT(7), .CNT_W(16)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .dec_valid_i(dec_valid_i), .dec_is_mul_i(dec_is_mul_i),
        .dec_rs1_i(dec_rs1_i), .dec_rs1_used_i(dec_rs1_used_i),
        .dec_rs2_i(dec_rs2_i), .dec_rs2_used_i(dec_rs2_used_i),
        .dec_rd_i(dec_rd_i), .dec_rd_we_i(dec_rd_we_i),
        .stall_o(stall_o), .issue_o(issue_o),
        .wb_valid_o(wb_valid_o), .wb_sel_mul_o(wb_sel_mul_o), .wb_rd_o(wb_rd_o),
        .pending_o(pending_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic dec(input logic v, input logic m, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic we);
        dec_valid_i = v; dec_is_mul_i = m;
        dec_rs1_i = rs1; dec_rs1_used_i = u1;
        dec_rs2_i = rs2; dec_rs2_used_i = u2;
        dec_rd_i = rd; dec_rd_we_i = we;
        #3;
    endtask

    task automatic idle();
        dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        rsn_i = 1'b0;
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
        chk("rst_issue_gated", {31'd0, issue_o}, 32'd0);
        chk("rst_stall_gated", {31'd0, stall_o}, 32'd0);
        cyc();
        idle();
        chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_pending", pending_o, 32'd0);
        chk("rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
        cyc();
        rsn_i = 1'b1;

        // Back-to-back independent ALU ops
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
        chk("t1_issue_x1", {31'd0, issue_o}, 32'd1);
        chk("t1_stall_x1", {31'd0, stall_o}, 32'd0);
        cyc();
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
        chk("t1_issue_x2", {31'd0, issue_o}, 32'd1);
        chk("t1_pending_a", pending_o, 32'h2);
        cyc();
        idle();
        chk("t1_wb_v_x1", {31'd0, wb_valid_o}, 32'd1);
        chk("t1_wb_rd_x1", {27'd0, wb_rd_o}, 32'd1);
        chk("t1_wb_sel_x1", {31'd0, wb_sel_mul_o}, 32'd0);
        chk("t1_pending_b", pending_o, 32'h6);
        cyc();
        idle();
        chk("t1_wb_v_x2", {31'd0, wb_valid_o}, 32'd1);
        chk("t1_wb_rd_x2", {27'd0, wb_rd_o}, 32'd2);
        cyc();
        idle();
        chk("t1_wb_idle", {31'd0, wb_valid_o}, 32'd0);
        chk("t1_pending_c", pending_o, 32'h0);

        // MUL x5 then ALU x6 colliding on the WB slot
        dec(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        chk("t2_issue_mul", {31'd0, issue_o}, 32'd1);
        cyc();
        for (int k = 1; k < 5; k++) begin
            idle();
            cyc();
        end
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        chk("t2_port_stall", {31'd0, stall_o}, 32'd1);
        chk("t2_port_noissue", {31'd0, issue_o}, 32'd0);
        chk("t2_pending", pending_o, 32'h20);
        cyc();
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        chk("t2_issue_alu", {31'd0, issue_o}, 32'd1);
        cyc();
        idle();
        chk("t2_wb_v_x5", {31'd0, wb_valid_o}, 32'd1);
        chk("t2_wb_rd_x5", {27'd0, wb_rd_o}, 32'd5);
        chk("t2_wb_sel_x5", {31'd0, wb_sel_mul_o}, 32'd1);
        cyc();
        idle();
        chk("t2_wb_rd_x6", {27'd0, wb_rd_o}, 32'd6);
        chk("t2_wb_sel_x6", {31'd0, wb_sel_mul_o}, 32'd0);
        chk("t2_cnt", {16'd0, stall_cnt_o}, 32'd1);
        cyc();

        // RAW on a multiplier result: 7 stall cycles
        dec(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cyc();
        for (int k = 1; k <= 7; k++) begin
            dec(1'b1, 1'b0, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1);
            chk($sformatf("t3_raw_stall_%0d", k), {31'd0, stall_o}, 32'd1);
            cyc();
        end
        dec(1'b1, 1'b0, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1);
        chk("t3_issue", {31'd0, issue_o}, 32'd1);
        chk("t3_nostall", {31'd0, stall_o}, 32'd0);
        cyc();
        idle();
        chk("t3_cnt", {16'd0, stall_cnt_o}, 32'd8);
        cyc();
        idle();
        chk("t3_wb_rd_x4", {27'd0, wb_rd_o}, 32'd4);
        cyc();

        // WAW on x7
        dec(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        cyc();
        for (int k = 1; k <= 7; k++) begin
            dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
            chk($sformatf("t4_waw_stall_%0d", k), {31'd0, stall_o}, 32'd1);
            chk($sformatf("t4_pending_%0d", k), pending_o, 32'h80);
            cyc();
        end
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        chk("t4_issue", {31'd0, issue_o}, 32'd1);
        chk("t4_pending_clear", pending_o, 32'h0);
        cyc();
        idle();
        chk("t4_cnt", {16'd0, stall_cnt_o}, 32'd15);
        cyc();
        idle();
        chk("t4_wb_rd_x7", {27'd0, wb_rd_o}, 32'd7);
        chk("t4_wb_sel_x7", {31'd0, wb_sel_mul_o}, 32'd0);
        cyc();

        // x0 never reserves and never stalls
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        chk("t5_issue_a", {31'd0, issue_o}, 32'd1);
        cyc();
        dec(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        chk("t5_issue_b", {31'd0, issue_o}, 32'd1);
        chk("t5_stall_b", {31'd0, stall_o}, 32'd0);
        chk("t5_pending_b", pending_o, 32'h0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            idle();
            chk($sformatf("t5_no_wb_%0d", k), {31'd0, wb_valid_o}, 32'd0);
            chk($sformatf("t5_pending_%0d", k), pending_o, 32'h0);
            cyc();
        end

        // Async reset with three reservations in flight
        dec(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        cyc();
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
        cyc();
        dec(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1);
        chk("t6_issue_x11", {31'd0, issue_o}, 32'd1);
        cyc();
        dec(1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1);
        chk("t6_pre_wb_rd", {27'd0, wb_rd_o}, 32'd10);
        chk("t6_pre_pending", pending_o, 32'hE00);
        chk("t6_pre_stall", {31'd0, stall_o}, 32'd1);
        rsn_i = 1'b0;
        #1;
        chk("t6_async_wb_v", {31'd0, wb_valid_o}, 32'd0);
        chk("t6_async_wb_rd", {27'd0, wb_rd_o}, 32'd0);
        chk("t6_async_pending", pending_o, 32'h0);
        chk("t6_async_stall", {31'd0, stall_o}, 32'd0);
        chk("t6_async_cnt", {16'd0, stall_cnt_o}, 32'd0);
        cyc();
        chk("t6_rst_issue", {31'd0, issue_o}, 32'd0);
        rsn_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            idle();
            chk($sformatf("t6_no_stale_wb_%0d", k), {31'd0, wb_valid_o}, 32'd0);
            cyc();
        end

        // Counter saturation from 0xFFFE
        dec(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        cyc();
        dec(1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        chk("t6_cnt_fffe", {16'd0, stall_cnt_o}, 32'hFFFE);
        cyc();
        dec(1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        chk("t6_cnt_ffff_a", {16'd0, stall_cnt_o}, 32'hFFFF);
        cyc();
        dec(1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        chk("t6_sat_stall", {31'd0, stall_o}, 32'd1);
        cyc();
        idle();
        chk("t6_cnt_ffff_b", {16'd0, stall_cnt_o}, 32'hFFFF);
        for (int k = 0; k < 6; k++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
